// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared constants and types for the VGA pixel pipeline.
//                1024x768 timing constants, text-box geometry, the latency of
//                the character overlay stage and the timing/colour bundle
//                carried from stage to stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

   // 1024x768 @ 60 Hz timing
   localparam int HOR_TOTAL_TIME  = 1344;
   localparam int HOR_ACTIVE_TIME = 1024;
   localparam int HOR_BLANK_START = 1024;
   localparam int HOR_BLANK_TIME  = 320;
   localparam int HOR_SYNC_START  = 1048;
   localparam int HOR_SYNC_TIME   = 136;

   localparam int VER_TOTAL_TIME  = 806;
   localparam int VER_ACTIVE_TIME = 768;
   localparam int VER_BLANK_START = 768;
   localparam int VER_BLANK_TIME  = 38;
   localparam int VER_SYNC_START  = 771;
   localparam int VER_SYNC_TIME   = 6;

   // Text box geometry
   localparam int CHAR_W    = 8;
   localparam int CHAR_H    = 16;
   localparam int TEXT_COLS = 32;
   localparam int TEXT_ROWS = 8;

   localparam int DRAW_CHAR_LATENCY = 4;

   // Timing and colour bundle travelling down the pipeline
   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblnk;
      logic        vblnk;
      logic [11:0] rgb;
   } vga_bus_t;

endpackage
`default_nettype wire

// File: rtl/font_rom.sv
`default_nettype none
// ============================================================================
//  Module      : font_rom
//  Description : 128-glyph 8x16 font ROM, one registered read per clock.
//                addr = {char_code[6:0], line[3:0]}; data is the glyph row,
//                MSB = leftmost pixel. The data register has no reset.
//  Ports       : clk  - pixel clock
//                addr - 11-bit glyph row address
//                data - registered 8-bit glyph row (1-cycle latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module font_rom (
   input  logic        clk,
   input  logic [10:0] addr,
   output logic [7:0]  data
);

   logic [7:0] data_q;

   // Each glyph is a 128-bit bitmap with row 0 in the top byte. Codes not
   // populated with a real glyph show a hollow "missing glyph" box.
   function automatic logic [7:0] glyph_row(input logic [6:0] code,
                                            input logic [3:0] line);
      logic [127:0] bitmap;
      logic [127:0] shifted;
      case (code)
         7'h20:   bitmap = 128'h00000000_00000000_00000000_00000000; // ' '
         7'h30:   bitmap = 128'h00007CC6_C6CEDEF6_E6C6C67C_00000000; // '0'
         7'h41:   bitmap = 128'h00001038_6CC6C6FE_C6C6C6C6_00000000; // 'A'
         7'h48:   bitmap = 128'h0000C6C6_C6C6FEC6_C6C6C6C6_00000000; // 'H'
         7'h52:   bitmap = 128'h0000FC66_66667C6C_666666E6_00000000; // 'R'
         default: bitmap = 128'hFF818181_81818181_81818181_818181FF;
      endcase
      shifted = bitmap >> {4'd15 - line, 3'b000};
      return shifted[7:0];
   endfunction

   always_ff @(posedge clk) begin
      data_q <= glyph_row(addr[10:4], addr[3:0]);
   end

   assign data = data_q;

endmodule
`default_nettype wire

// File: rtl/draw_rect_char.sv
`default_nettype none
// ============================================================================
//  Module      : draw_rect_char
//  Description : Overlays a 32x8-character (256x128 pixel) text box on the
//                VGA pixel stream. Generates char_xy for the upstream char
//                ROM, receives char_code one cycle later, looks up the glyph
//                row in font_rom and paints TEXT_COLOR on set glyph bits.
//                All outputs are delayed by exactly 4 clocks.
//  Ports       : clk, rst            - pixel clock, sync active-high reset
//                *_in                - incoming timing and colour stream
//                char_code           - code from char ROM (1 cycle after xy)
//                char_xy             - {column[4:0], row[2:0]} to char ROM
//                *_out               - stream delayed by 4 clocks
//  Revision    : 1.0 - initial release
// ============================================================================
module draw_rect_char
   import vga_pkg::*;
#(
   parameter int          XPOS       = 100,
   parameter int          YPOS       = 200,
   parameter logic [11:0] TEXT_COLOR = 12'hFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] hcount_in,
   input  logic [10:0] vcount_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        hblnk_in,
   input  logic        vblnk_in,
   input  logic [11:0] rgb_in,
   input  logic [6:0]  char_code,
   output logic [7:0]  char_xy,
   output logic [10:0] hcount_out,
   output logic [10:0] vcount_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        hblnk_out,
   output logic        vblnk_out,
   output logic [11:0] rgb_out
);

   localparam logic [11:0] C_XPOS = 12'(XPOS);
   localparam logic [11:0] C_YPOS = 12'(YPOS);
   localparam int          C_LAST = DRAW_CHAR_LATENCY - 1;

   // Stage 1 combinational
   logic [11:0] rel_x;
   logic [11:0] rel_y;
   logic        inside_d;
   logic [7:0]  char_xy_d;
   vga_bus_t    bus_d;

   // Pipeline registers
   logic [7:0]  char_xy_q;
   logic [3:0]  line_s1_q;
   logic [3:0]  line_s2_q;
   logic [2:0]  bit_s1_q;
   logic [2:0]  bit_s2_q;
   logic [2:0]  bit_s3_q;
   logic        inside_s1_q;
   logic        inside_s2_q;
   logic        inside_s3_q;
   vga_bus_t    bus_q [DRAW_CHAR_LATENCY];

   // Font lookup and output stage
   logic [10:0] font_addr;
   logic [7:0]  glyph;
   logic        pix;
   vga_bus_t    out_d;

   always_comb begin
      // 12-bit two's-complement offsets; inputs are at most 2047 and the
      // box origin at most 1023, so neither subtraction can wrap.
      rel_x = {1'b0, hcount_in} - C_XPOS;
      rel_y = {1'b0, vcount_in} - C_YPOS;
      // Sign bit clear means >= 0; no bits set above bit 7 (x) / bit 6 (y)
      // means < 256 / < 128.
      inside_d  = !rel_x[11] && (rel_x[10:8] == 3'd0) &&
                  !rel_y[11] && (rel_y[10:7] == 4'd0);
      // Held at 0 outside the box so the char ROM address stays quiet.
      char_xy_d = inside_d ? {rel_x[7:3], rel_y[6:4]} : 8'h00;

      bus_d.hcount = hcount_in;
      bus_d.vcount = vcount_in;
      bus_d.hsync  = hsync_in;
      bus_d.vsync  = vsync_in;
      bus_d.hblnk  = hblnk_in;
      bus_d.vblnk  = vblnk_in;
      bus_d.rgb    = rgb_in;
   end

   // char_code arrives registered by the char ROM in step with line_s2_q.
   assign font_addr = {char_code, line_s2_q};

   font_rom u_font_rom (
      .clk  (clk),
      .addr (font_addr),
      .data (glyph)
   );

   always_comb begin
      pix   = glyph[3'd7 - bit_s3_q];
      out_d = bus_q[C_LAST-1];
      if (bus_q[C_LAST-1].hblnk || bus_q[C_LAST-1].vblnk) begin
         out_d.rgb = 12'h000;
      end else if (inside_s3_q && pix) begin
         out_d.rgb = TEXT_COLOR;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         char_xy_q   <= 8'h00;
         line_s1_q   <= 4'd0;
         line_s2_q   <= 4'd0;
         bit_s1_q    <= 3'd0;
         bit_s2_q    <= 3'd0;
         bit_s3_q    <= 3'd0;
         inside_s1_q <= 1'b0;
         inside_s2_q <= 1'b0;
         inside_s3_q <= 1'b0;
         for (int k = 0; k < DRAW_CHAR_LATENCY; k++) begin
            bus_q[k] <= '0;
         end
      end else begin
         char_xy_q   <= char_xy_d;
         line_s1_q   <= rel_y[3:0];
         bit_s1_q    <= rel_x[2:0];
         inside_s1_q <= inside_d;

         line_s2_q   <= line_s1_q;
         bit_s2_q    <= bit_s1_q;
         inside_s2_q <= inside_s1_q;

         bit_s3_q    <= bit_s2_q;
         inside_s3_q <= inside_s2_q;

         bus_q[0] <= bus_d;
         for (int k = 1; k < C_LAST; k++) begin
            bus_q[k] <= bus_q[k-1];
         end
         bus_q[C_LAST] <= out_d;
      end
   end

   assign char_xy    = char_xy_q;
   assign hcount_out = bus_q[C_LAST].hcount;
   assign vcount_out = bus_q[C_LAST].vcount;
   assign hsync_out  = bus_q[C_LAST].hsync;
   assign vsync_out  = bus_q[C_LAST].vsync;
   assign hblnk_out  = bus_q[C_LAST].hblnk;
   assign vblnk_out  = bus_q[C_LAST].vblnk;
   assign rgb_out    = bus_q[C_LAST].rgb;

endmodule
`default_nettype wire

// File: doc/draw_rect_char.md
Name: draw_rect_char

Overview:
- VGA pipeline stage that overlays a 32x8-character text box onto the incoming pixel stream.
- Font cells are 8x16 pixels, so the box is 256x128 pixels.
- From the beam position it generates char_xy for the upstream character-code ROM and receives the 7-bit char_code back one cycle later.
- It then looks up the glyph row in an internal font ROM and replaces rgb with the text colour where the glyph bit is set.
- Sits between the background/sprite stages and the VGA output register stage.

Parameters:
- XPOS, 100, left edge of the text box in pixels (0..1023).
- YPOS, 200, top edge of the text box in pixels (0..767).
- TEXT_COLOR, 12'hFFF, RGB444 colour of set glyph pixels.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- hcount_in  in  11  horizontal beam position.
- vcount_in  in  11  vertical beam position.
- hsync_in  in  1  horizontal sync.
- vsync_in  in  1  vertical sync.
- hblnk_in  in  1  horizontal blanking.
- vblnk_in  in  1  vertical blanking.
- rgb_in  in  12  incoming pixel colour.
- char_code  in  7  code returned by the char ROM; registered there, valid 1 cycle after char_xy.
- char_xy  out  8  {column[4:0], row[2:0]} sent to the char ROM.
- hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out  out  same widths as inputs  stream delayed by 4 cycles.

Behaviour:
- Reset: every output and every internal pipeline register is 0, including char_xy and rgb_out. Reset mid-frame flushes the pipeline; after deassertion outputs become valid again 4 cycles later.
- Stage 1 (cycle n+1):
  - rel_x = hcount_in - XPOS and rel_y = vcount_in - YPOS, both 12-bit signed.
  - inside = (rel_x >= 0) && (rel_x < 256) && (rel_y >= 0) && (rel_y < 128).
  - Register char_xy <= inside ? {rel_x[7:3], rel_y[6:4]} : 8'h00.
  - Register line = rel_y[3:0], bit_idx = rel_x[2:0], inside, and the timing/rgb bundle.
- Stage 2 (n+2):
  - char_code is valid; form font address {char_code, line} (11 bits).
  - Delay line, bit_idx, inside and the bundle.
- Stage 3 (n+3): font ROM registers the 8-bit glyph row; MSB is the leftmost pixel.
- Stage 4 (n+4), output register:
  - pix = glyph[7 - bit_idx].
  - rgb_out = (hblnk || vblnk) ? 12'h000 : (inside && pix) ? TEXT_COLOR : rgb_in(delayed).
- All other outputs are pure 4-cycle delays of their inputs, unconditional.
- Latency is exactly 4 cycles for every output; no bubbles, one pixel per clock, no stalls.
- Boundary cases:
  - hcount_in == XPOS+255 is inside; XPOS+256 is outside.
  - Same rule vertically at YPOS+127 / YPOS+128.
  - A box clipped by the screen edge needs no special handling, since hcount never reaches the clipped region.
  - If XPOS+256 > 2047, the 12-bit arithmetic prevents wrap-around.
- While outside the box, char_xy is held at 0, so the char ROM address is stable and no spurious glyph appears.
- Blanking overrides text colour even inside the box.

Decomposition:
- Shared package `vga_pkg`:
  - HOR/VER total, active and blank constants.
  - CHAR_W=8, CHAR_H=16, TEXT_COLS=32, TEXT_ROWS=8.
  - DRAW_CHAR_LATENCY=4.
  - A typedef for the timing bundle struct (hcount, vcount, hsync, vsync, hblnk, vblnk, rgb).
- One sub-module, `font_rom`:
  - Inputs: clk, addr[10:0]. Output: registered data[7:0].
  - Holds the 128-glyph 8x16 font, 1-cycle latency, no reset on the data array.
- The delay line is a generic 4-stage register chain of the bundle struct, written inline; no extra module.

Test Plan:
- Reset held 5 cycles with active stimulus -> all outputs 0 and char_xy 0 throughout; first valid rgb_out appears exactly 4 cycles after rst drops.
- hcount_in=100, vcount_in=200 -> char_xy=8'h00 on the next cycle; hcount_in=108, vcount_in=216 -> char_xy=8'h09 (col 1, row 1); hcount_in=355, vcount_in=327 -> char_xy=8'hFF.
- Char-ROM model returns 0x52 ('R') for char_xy 0; font row 2 of 'R' is 8'b11111100 -> pixels at hcount_in=100..105 with vcount_in=202 give rgb_out=12'hFFF, and hcount_in=106..107 give the delayed rgb_in (12'h0A5).
- Edges: hcount_in=99 and hcount_in=356 with vcount_in=210 -> rgb_out = delayed rgb_in and char_xy=0; vcount_in=328 -> outside.
- hblnk_in=1 inside the box with a set glyph bit -> rgb_out=12'h000 and hblnk_out=1 four cycles later.
- Full 1024x768 frame sweep against a reference model -> bit-exact rgb_out and timing outputs equal inputs delayed by 4; a reset pulse at mid-frame line 300 recovers within 4 cycles.
